// File: rtl/hpm_counter_bank.sv
// Machine-mode counter/CSR unit: mcycle, minstret, NUM_HPM event counters with selectors,
// mcountinhibit and sticky overflow status behind one read-modify-write CSR port.
module hpm_counter_bank #(
  parameter int XLEN       = 64,
  parameter int NUM_HPM    = 4,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_csr_en,
  input  logic [1:0]            i_csr_op,
  input  logic [11:0]           i_csr_addr,
  input  logic [XLEN-1:0]       i_csr_wdata,
  output logic [XLEN-1:0]       o_csr_rdata,
  output logic                  o_csr_illegal,
  input  logic                  i_retire,
  input  logic [NUM_EVENTS-1:0] i_event_vec,
  output logic [NUM_HPM-1:0]    o_ovf_status,
  output logic                  o_ovf_irq
);

  localparam int SELW = $clog2(NUM_EVENTS + 1);
  localparam int INHW = NUM_HPM + 3;

  logic [XLEN-1:0]    r_mcycle;
  logic [XLEN-1:0]    r_minstret;
  logic [XLEN-1:0]    r_hpm [NUM_HPM];
  logic [SELW-1:0]    r_sel [NUM_HPM];
  logic [INHW-1:0]    r_inhibit;
  logic [NUM_HPM-1:0] r_ovf;
  logic               r_ovf_irq;

  logic [4:0]         w_idx;
  logic               w_is_inh, w_is_evt, w_is_ovf, w_is_ctr, w_is_shd;
  logic [NUM_HPM-1:0] w_hpm_hit;
  logic               w_wr_req, w_illegal, w_do_wr;
  logic [XLEN-1:0]    w_rdata, w_new;
  logic               w_wr_inh, w_wr_ovf, w_wr_cyc, w_wr_ins;
  logic [NUM_HPM-1:0] w_wr_hpm, w_wr_sel, w_hpm_cnt, w_ovf_set;

  always_comb begin
    w_idx    = i_csr_addr[4:0];
    w_is_inh = (i_csr_addr == 12'h320);
    w_is_evt = (i_csr_addr[11:5] == 7'h19) && (w_idx >= 5'd3);
    w_is_ovf = (i_csr_addr == 12'h7C0);
    w_is_ctr = (i_csr_addr[11:5] == 7'h58) && (w_idx != 5'd1);
    w_is_shd = (i_csr_addr[11:5] == 7'h60) && (w_idx != 5'd1);
    for (int k = 0; k < NUM_HPM; k++) begin
      w_hpm_hit[k] = (w_idx == 5'(k + 3));
    end
  end

  // RS/RC with a zero mask is a pure read, so it is legal even on a shadow.
  assign w_wr_req  = i_csr_en && ((i_csr_op == 2'b01) || (i_csr_op[1] && (i_csr_wdata != '0)));
  assign w_illegal = i_csr_en &&
                     (!(w_is_inh || w_is_evt || w_is_ovf || w_is_ctr || w_is_shd) ||
                      (w_is_shd && w_wr_req));
  assign w_do_wr   = w_wr_req && !w_illegal;

  always_comb begin
    w_rdata = '0;
    if (i_csr_en) begin
      if (w_is_inh) begin
        w_rdata = XLEN'(r_inhibit);
      end else if (w_is_ovf) begin
        w_rdata = XLEN'(r_ovf);
      end else if (w_is_evt) begin
        for (int k = 0; k < NUM_HPM; k++) begin
          if (w_hpm_hit[k]) w_rdata = XLEN'(r_sel[k]);
        end
      end else if (w_is_ctr || w_is_shd) begin
        if (w_idx == 5'd0) w_rdata = r_mcycle;
        if (w_idx == 5'd2) w_rdata = r_minstret;
        for (int k = 0; k < NUM_HPM; k++) begin
          if (w_hpm_hit[k]) w_rdata = r_hpm[k];
        end
      end
    end
  end

  always_comb begin
    case (i_csr_op)
      2'b10:   w_new = w_rdata | i_csr_wdata;
      2'b11:   w_new = w_rdata & ~i_csr_wdata;
      default: w_new = i_csr_wdata;
    endcase
  end

  assign w_wr_inh = w_do_wr && w_is_inh;
  assign w_wr_ovf = w_do_wr && w_is_ovf;
  assign w_wr_cyc = w_do_wr && w_is_ctr && (w_idx == 5'd0);
  assign w_wr_ins = w_do_wr && w_is_ctr && (w_idx == 5'd2);

  always_comb begin
    for (int k = 0; k < NUM_HPM; k++) begin
      w_wr_hpm[k]  = w_do_wr && w_is_ctr && w_hpm_hit[k];
      w_wr_sel[k]  = w_do_wr && w_is_evt && w_hpm_hit[k];
      w_hpm_cnt[k] = 1'b0;
      for (int e = 0; e < NUM_EVENTS; e++) begin
        if ((r_sel[k] == SELW'(e + 1)) && i_event_vec[e]) w_hpm_cnt[k] = 1'b1;
      end
      w_hpm_cnt[k] = w_hpm_cnt[k] && !r_inhibit[3 + k];
      // A software write replaces the increment, so it can never overflow.
      w_ovf_set[k] = w_hpm_cnt[k] && !w_wr_hpm[k] && (&r_hpm[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mcycle   <= '0;
      r_minstret <= '0;
      r_inhibit  <= '0;
      r_ovf      <= '0;
      r_ovf_irq  <= 1'b0;
      for (int k = 0; k < NUM_HPM; k++) begin
        r_hpm[k] <= '0;
        r_sel[k] <= '0;
      end
    end else begin
      if (w_wr_inh) r_inhibit <= {w_new[INHW-1:2], 1'b0, w_new[0]};

      if (w_wr_cyc)          r_mcycle <= w_new;
      else if (!r_inhibit[0]) r_mcycle <= r_mcycle + XLEN'(1);

      if (w_wr_ins)                      r_minstret <= w_new;
      else if (i_retire && !r_inhibit[2]) r_minstret <= r_minstret + XLEN'(1);

      for (int k = 0; k < NUM_HPM; k++) begin
        if (w_wr_sel[k]) r_sel[k] <= w_new[SELW-1:0];
        if (w_wr_hpm[k])       r_hpm[k] <= w_new;
        else if (w_hpm_cnt[k]) r_hpm[k] <= r_hpm[k] + XLEN'(1);
      end

      // Hardware set wins over a same-cycle software clear.
      r_ovf     <= (w_wr_ovf ? w_new[NUM_HPM-1:0] : r_ovf) | w_ovf_set;
      r_ovf_irq <= |r_ovf;
    end
  end

  assign o_csr_rdata   = w_rdata;
  assign o_csr_illegal = w_illegal;
  assign o_ovf_status  = r_ovf;
  assign o_ovf_irq     = r_ovf_irq;

endmodule

// File: doc/hpm_counter_bank.md
# hpm_counter_bank

Parametrised machine-mode counter/CSR unit replacing the fixed counter logic in the register file: mcycle, minstret and NUM_HPM programmable hardware performance counters, each with an event selector, plus mcountinhibit and a sticky overflow status. It sits beside the register file in the pipeline. The CSR stage drives a single read-modify-write port with csrrw/csrrs/csrrc semantics. Writeback drives the retire strobe and per-cycle event lines.

## Interface
- XLEN, 64: counter and CSR data width.
- NUM_HPM, 4: implemented mhpmcounter3..(3+NUM_HPM-1); legal range 1..29.
- NUM_EVENTS, 8: width of event_vec.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- csr_en  in  1  CSR access valid this cycle.
- csr_op  in  2  00 read-only, 01 RW, 10 RS (set), 11 RC (clear).
- csr_addr  in  12  CSR address.
- csr_wdata  in  XLEN  write/mask operand.
- csr_rdata  out  XLEN  combinational read data (pre-update value).
- csr_illegal  out  1  combinational; access must trap, no state change.
- retire  in  1  one valid instruction retired this cycle.
- event_vec  in  NUM_EVENTS  per-cycle event pulses.
- ovf_status  out  NUM_HPM  sticky overflow bits, bit k = mhpmcounter(3+k).
- ovf_irq  out  1  registered OR of ovf_status.

## Operation
- Address map:
  - mcountinhibit 0x320: bit0 CY, bit2 IR, bit 3+k HPM k; bit1 and unimplemented bits read 0.
  - mhpmevent(3+k) 0x323+k: holds $clog2(NUM_EVENTS+1) bits; upper bits read 0.
  - mcycle 0xB00, minstret 0xB02, mhpmcounter(3+k) 0xB03+k.
  - mhpmovf 0x7C0: ovf_status in low bits.
  - Shadows 0xC00/0xC02/0xC03+k: read-only copies.
- Unimplemented counter/event slots (index ≥ 3+NUM_HPM, ≤ 31) read 0, ignore writes, are not illegal.
- csr_illegal=1 in two cases:
  - any other unmapped address;
  - a write to a 0xCxx shadow. A write is op=01, or op=10/11 with csr_wdata≠0.
- New value: RW → wdata; RS → old|wdata; RC → old&~wdata. RS/RC with wdata=0 is a read only and performs no write.
- Counting, each cycle, unless inhibited:
  - mcycle +1;
  - minstret +1 if retire;
  - HPM k +1 if its selector v is in 1..NUM_EVENTS and event_vec[v-1]=1. v=0 or v>NUM_EVENTS never counts.
- Overflow: an HPM increment from all-ones wraps to 0 and sets ovf_status[k]. Bits stay set until cleared by a write to mhpmovf. Hardware set wins over a same-cycle software clear of that bit.
- mcycle/minstret wrap silently.

## Timing
- Reset: all counters, selectors, mcountinhibit, ovf_status = 0; ovf_irq = 0 the cycle after reset deasserts.
- csr_rdata and csr_illegal are combinational from csr_en/csr_op/csr_addr. csr_rdata shows the value before this edge's update. It is 0 when csr_en=0.
- A CSR write to a counter takes effect at the next edge and replaces that cycle's increment: the written value is stored exactly, with no +1.
- A write to mcountinhibit/mhpmevent affects counting from the following cycle.
- An illegal access changes nothing.
- ovf_irq lags ovf_status by one cycle.
- Reset asserted mid-operation clears everything at that edge, overriding a same-cycle write.

## Test plan
- Reset, then 10 idle cycles with retire=0 → mcycle=10, minstret=0, ovf_irq=0.
- Write mhpmevent3=2, pulse event_vec[1] on 5 cycles and event_vec[0] on 3 cycles → mhpmcounter3=5. Selector 0 or 9 (NUM_EVENTS=8) → stays 0.
- Write mhpmcounter3=all-ones, then one event → counter 0, ovf_status[0]=1, ovf_irq=1 next cycle. csrrc 0x7C0 with mask 1 → status clears. Clear in the same cycle as a new overflow → bit stays 1.
- Set mcountinhibit bit0 via csrrs 0x320 mask 1 → mcycle frozen. csrrc same mask → resumes one cycle later.
- csrrw 0xB00=100 while counting → next-cycle read returns 100, then 101.
- Write 0xC00 → csr_illegal=1, no state change. csrrs 0xC00 with wdata 0 → legal read. Access 0x123 → illegal. Read 0xB1F (NUM_HPM=4) → 0, not illegal.
